// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding, load-use/RAW interlock, branch flush and
// multi-cycle-op stall sequencer, with saturating stall/flush event counters.
module hazard_forward_unit #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned FWD_EN = 1,
   parameter int unsigned MC_LAT = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1_id,
   input  logic [REG_AW-1:0] rs2_id,
   input  logic [REG_AW-1:0] rs1_ex,
   input  logic [REG_AW-1:0] rs2_ex,
   input  logic [REG_AW-1:0] rd_ex,
   input  logic [REG_AW-1:0] rd_mem,
   input  logic [REG_AW-1:0] rd_wb,
   input  logic              RUWrex,
   input  logic              RUWrme,
   input  logic              RUWrwb,
   input  logic              mem_rd_ex,
   input  logic              mc_start_ex,
   input  logic              branch_taken,
   output logic [1:0]        control1,
   output logic [1:0]        control2,
   output logic              stall_if,
   output logic              stall_id,
   output logic              stall_ex,
   output logic              flush_id,
   output logic              flush_ex,
   output logic              bubble_mem,
   output logic              mc_busy,
   output logic              mc_done,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int unsigned MC_CNT_W = 8;
   localparam bit                  FWD      = (FWD_EN != 0);
   localparam bit                  MC_SHORT = (MC_LAT == 2);
   localparam logic [MC_CNT_W-1:0] MC_INIT  = MC_CNT_W'(MC_LAT - 2);
   localparam logic [1:0]          SEL_RF   = 2'b00;
   localparam logic [1:0]          SEL_MEM  = 2'b01;
   localparam logic [1:0]          SEL_WB   = 2'b10;

   typedef enum logic [1:0] {
      MC_IDLE = 2'd0,
      MC_BUSY = 2'd1,
      MC_DONE = 2'd2
   } mc_state_e;

   mc_state_e           state;
   mc_state_e           state_nxt;
   logic [MC_CNT_W-1:0] cnt;
   logic [MC_CNT_W-1:0] cnt_nxt;

   logic wr_ex_ok;
   logic wr_mem_ok;
   logic wr_wb_ok;
   logic load_use;
   logic raw_hit;
   logic id_hazard;
   logic mc_stall;

   // Writers that can actually produce a hazard (x0 is never a source).
   always_comb begin
      wr_ex_ok  = RUWrex && (rd_ex  != '0);
      wr_mem_ok = RUWrme && (rd_mem != '0);
      wr_wb_ok  = RUWrwb && (rd_wb  != '0);
   end

   // ID-stage hazard detection: load-use with forwarding, full RAW without.
   always_comb begin
      load_use = mem_rd_ex && wr_ex_ok && ((rd_ex == rs1_id) || (rd_ex == rs2_id));
      raw_hit  = (wr_ex_ok  && ((rd_ex  == rs1_id) || (rd_ex  == rs2_id))) ||
                 (wr_mem_ok && ((rd_mem == rs1_id) || (rd_mem == rs2_id))) ||
                 (wr_wb_ok  && ((rd_wb  == rs1_id) || (rd_wb  == rs2_id)));
      id_hazard = FWD ? load_use : raw_hit;
   end

   // EX operand selects; MEM result is newer than WB so it takes precedence.
   always_comb begin
      control1 = SEL_RF;
      control2 = SEL_RF;
      if (!rst && FWD) begin
         if (wr_mem_ok && (rs1_ex == rd_mem))     control1 = SEL_MEM;
         else if (wr_wb_ok && (rs1_ex == rd_wb))  control1 = SEL_WB;
         if (wr_mem_ok && (rs2_ex == rd_mem))     control2 = SEL_MEM;
         else if (wr_wb_ok && (rs2_ex == rd_wb))  control2 = SEL_WB;
      end
   end

   // Multi-cycle sequencer state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MC_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Sequencer next state plus pipeline control, priority mc > branch > hazard.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      mc_stall   = 1'b0;
      mc_done    = 1'b0;
      stall_if   = 1'b0;
      stall_id   = 1'b0;
      stall_ex   = 1'b0;
      flush_id   = 1'b0;
      flush_ex   = 1'b0;
      bubble_mem = 1'b0;
      mc_busy    = (state != MC_IDLE);

      unique case (state)
         MC_IDLE: begin
            if (mc_start_ex) begin
               mc_stall = 1'b1;
               if (MC_SHORT) begin
                  state_nxt = MC_DONE;
               end else begin
                  cnt_nxt   = MC_INIT;
                  state_nxt = MC_BUSY;
               end
            end
         end
         MC_BUSY: begin
            mc_stall = 1'b1;
            cnt_nxt  = cnt - MC_CNT_W'(1);
            if (cnt <= MC_CNT_W'(1)) state_nxt = MC_DONE;
         end
         MC_DONE: begin
            // The finishing op is still in EX, so its start flag is ignored here.
            mc_done   = 1'b1;
            state_nxt = MC_IDLE;
         end
         default: begin
            state_nxt = MC_IDLE;
         end
      endcase

      if (rst) begin
         mc_done = 1'b0;
      end else if (mc_stall) begin
         stall_if   = 1'b1;
         stall_id   = 1'b1;
         stall_ex   = 1'b1;
         bubble_mem = 1'b1;
      end else if (branch_taken) begin
         flush_id = 1'b1;
         flush_ex = 1'b1;
      end else if (id_hazard) begin
         stall_if = 1'b1;
         stall_id = 1'b1;
         flush_ex = 1'b1;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_if && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_id && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: default instance plus a
// no-forwarding / MC_LAT=2 / 4-bit-counter instance sharing the same inputs.
module tb_hazard_forward_unit;

   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
   logic          RUWrex, RUWrme, RUWrwb, mem_rd_ex, mc_start_ex, branch_taken;

   logic [1:0]  d_control1, d_control2;
   logic        d_stall_if, d_stall_id, d_stall_ex, d_flush_id, d_flush_ex;
   logic        d_bubble_mem, d_mc_busy, d_mc_done;
   logic [15:0] d_stall_cnt, d_flush_cnt;

   logic [1:0]  n_control1, n_control2;
   logic        n_stall_if, n_stall_id, n_stall_ex, n_flush_id, n_flush_ex;
   logic        n_bubble_mem, n_mc_busy, n_mc_done;
   logic [3:0]  n_stall_cnt, n_flush_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hazard_forward_unit #(.REG_AW(AW), .FWD_EN(1), .MC_LAT(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst),
      .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
      .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
      .RUWrex(RUWrex), .RUWrme(RUWrme), .RUWrwb(RUWrwb),
      .mem_rd_ex(mem_rd_ex), .mc_start_ex(mc_start_ex), .branch_taken(branch_taken),
      .control1(d_control1), .control2(d_control2),
      .stall_if(d_stall_if), .stall_id(d_stall_id), .stall_ex(d_stall_ex),
      .flush_id(d_flush_id), .flush_ex(d_flush_ex), .bubble_mem(d_bubble_mem),
      .mc_busy(d_mc_busy), .mc_done(d_mc_done),
      .stall_cnt(d_stall_cnt), .flush_cnt(d_flush_cnt)
   );

   hazard_forward_unit #(.REG_AW(AW), .FWD_EN(0), .MC_LAT(2), .CNT_W(4)) u_nf (
      .clk(clk), .rst(rst),
      .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
      .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
      .RUWrex(RUWrex), .RUWrme(RUWrme), .RUWrwb(RUWrwb),
      .mem_rd_ex(mem_rd_ex), .mc_start_ex(mc_start_ex), .branch_taken(branch_taken),
      .control1(n_control1), .control2(n_control2),
      .stall_if(n_stall_if), .stall_id(n_stall_id), .stall_ex(n_stall_ex),
      .flush_id(n_flush_id), .flush_ex(n_flush_ex), .bubble_mem(n_bubble_mem),
      .mc_busy(n_mc_busy), .mc_done(n_mc_done),
      .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_inputs();
      rs1_id = '0; rs2_id = '0; rs1_ex = '0; rs2_ex = '0;
      rd_ex = '0; rd_mem = '0; rd_wb = '0;
      RUWrex = 1'b0; RUWrme = 1'b0; RUWrwb = 1'b0;
      mem_rd_ex = 1'b0; mc_start_ex = 1'b0; branch_taken = 1'b0;
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clr_inputs();
      step();
      rst = 1'b0;
   endtask

   initial begin
      // Reset forces all controls low even with active requests.
      clr_inputs();
      rst = 1'b1;
      rs1_ex = 5'd5; rd_mem = 5'd5; RUWrme = 1'b1;
      mc_start_ex = 1'b1; branch_taken = 1'b1;
      #1;
      chk("rst_control1", 32'(d_control1), 32'd0);
      chk("rst_stall_if", 32'(d_stall_if), 32'd0);
      chk("rst_flush_id", 32'(d_flush_id), 32'd0);
      chk("rst_bubble",   32'(d_bubble_mem), 32'd0);
      step();
      chk("rst_mc_busy",   32'(d_mc_busy), 32'd0);
      chk("rst_stall_cnt", 32'(d_stall_cnt), 32'd0);
      chk("rst_flush_cnt", 32'(d_flush_cnt), 32'd0);
      rst = 1'b0;
      clr_inputs();

      // Forwarding select priority.
      rs1_ex = 5'd5; rd_mem = 5'd5; RUWrme = 1'b1; rd_wb = 5'd5; RUWrwb = 1'b1;
      #1;
      chk("fwd_mem_wins", 32'(d_control1), 32'd1);
      chk("fwd_c2_none",  32'(d_control2), 32'd0);
      chk("nofwd_c1",     32'(n_control1), 32'd0);
      RUWrme = 1'b0;
      #1;
      chk("fwd_wb", 32'(d_control1), 32'd2);
      rs1_ex = 5'd0; rd_mem = 5'd0; RUWrme = 1'b1; rs2_ex = 5'd9; rd_wb = 5'd9;
      #1;
      chk("fwd_x0_ignored", 32'(d_control1), 32'd0);
      chk("fwd_c2_wb",      32'(d_control2), 32'd2);
      clr_inputs();

      // Load-use interlock.
      do_reset();
      mem_rd_ex = 1'b1; RUWrex = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7;
      #1;
      chk("lu_stall_if", 32'(d_stall_if), 32'd1);
      chk("lu_stall_id", 32'(d_stall_id), 32'd1);
      chk("lu_flush_ex", 32'(d_flush_ex), 32'd1);
      chk("lu_stall_ex", 32'(d_stall_ex), 32'd0);
      chk("lu_flush_id", 32'(d_flush_id), 32'd0);
      step();
      chk("lu_stall_cnt", 32'(d_stall_cnt), 32'd1);
      rd_ex = 5'd0; rs2_id = 5'd0;
      #1;
      chk("lu_x0_no_stall", 32'(d_stall_if), 32'd0);
      step();
      chk("lu_x0_cnt", 32'(d_stall_cnt), 32'd1);

      // Multi-cycle sequencing: MC_LAT=4 on u_dut, MC_LAT=2 on u_nf.
      do_reset();
      mc_start_ex = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("mc4_stall_c%0d", i),  32'(d_stall_if),   32'(i < 3));
         chk($sformatf("mc4_bubble_c%0d", i), 32'(d_bubble_mem), 32'(i < 3));
         chk($sformatf("mc4_done_c%0d", i),   32'(d_mc_done),    32'(i == 3));
         chk($sformatf("mc4_busy_c%0d", i),   32'(d_mc_busy),    32'(i != 0));
         chk($sformatf("mc2_stall_c%0d", i),  32'(n_stall_if),   32'(i % 2 == 0));
         chk($sformatf("mc2_done_c%0d", i),   32'(n_mc_done),    32'(i % 2 == 1));
         step();
      end
      mc_start_ex = 1'b0;
      #1;
      chk("mc4_idle_busy", 32'(d_mc_busy), 32'd0);
      chk("mc4_idle_done", 32'(d_mc_done), 32'd0);
      chk("mc4_stall_cnt", 32'(d_stall_cnt), 32'd3);
      chk("mc2_stall_cnt", 32'(n_stall_cnt), 32'd2);

      // Branch flush beats load-use; mc stall beats branch.
      do_reset();
      mem_rd_ex = 1'b1; RUWrex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7; branch_taken = 1'b1;
      #1;
      chk("br_flush_id", 32'(d_flush_id), 32'd1);
      chk("br_flush_ex", 32'(d_flush_ex), 32'd1);
      chk("br_stall_if", 32'(d_stall_if), 32'd0);
      chk("br_stall_id", 32'(d_stall_id), 32'd0);
      step();
      chk("br_flush_cnt", 32'(d_flush_cnt), 32'd1);
      chk("br_stall_cnt", 32'(d_stall_cnt), 32'd0);
      clr_inputs();
      mc_start_ex = 1'b1; branch_taken = 1'b1;
      #1;
      chk("mcbr_stall_if", 32'(d_stall_if), 32'd1);
      chk("mcbr_flush_id", 32'(d_flush_id), 32'd0);
      step();

      // Reset while BUSY abandons the op.
      clr_inputs();
      #1;
      chk("rb_busy_before", 32'(d_mc_busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("rb_stall_forced", 32'(d_stall_if), 32'd0);
      chk("rb_done_forced",  32'(d_mc_done),  32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("rb_busy_after", 32'(d_mc_busy), 32'd0);
      chk("rb_stall_if",   32'(d_stall_if), 32'd0);
      chk("rb_stall_cnt",  32'(d_stall_cnt), 32'd0);
      chk("rb_flush_cnt",  32'(d_flush_cnt), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("rb_no_done_%0d", i), 32'(d_mc_done), 32'd0);
      end

      // No-forwarding RAW stall held while match persists; 4-bit counter saturates.
      do_reset();
      rd_mem = 5'd3; RUWrme = 1'b1; rs1_id = 5'd3; rs1_ex = 5'd3;
      #1;
      chk("raw_fwd_on_c1", 32'(d_control1), 32'd1);
      chk("raw_dut_nostall", 32'(d_stall_if), 32'd0);
      for (int i = 0; i < 20; i++) begin
         #1;
         chk($sformatf("raw_stall_c%0d", i), 32'(n_stall_if), 32'd1);
         if (i == 0) begin
            chk("raw_flush_ex", 32'(n_flush_ex), 32'd1);
            chk("raw_c1_zero",  32'(n_control1), 32'd0);
         end
         step();
      end
      chk("raw_cnt_sat", 32'(n_stall_cnt), 32'd15);
      rd_mem = 5'd0; RUWrme = 1'b0; rs1_id = 5'd0;
      rd_wb = 5'd4; RUWrwb = 1'b1; rs2_id = 5'd4;
      #1;
      chk("raw_wb_stall", 32'(n_stall_if), 32'd1);
      RUWrwb = 1'b0;
      #1;
      chk("raw_clear", 32'(n_stall_if), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
